// File: rtl/mem_window_reader_if.sv
// Bundled handshake and memory bus for mem_window_reader.
// master = the reader block, slave = memory/downstream/result side.
interface mem_window_reader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [1:0]        ksize;
    logic              busy;
    logic [ADDR_W-1:0] mem_index;
    logic              mem_write;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_all;
    logic [DATA_W-1:0] mem_rdata;
    logic              win_valid;
    logic [DATA_W-1:0] win_data;
    logic              win_last;
    logic              win_ready;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_addr;
    logic              res_ready;
    logic              done;

    modport master (
        input  start, base, stride, ksize, mem_rdata, win_ready,
               res_valid, res_data, res_addr,
        output busy, mem_index, mem_write, mem_write_data, mem_write_all,
               win_valid, win_data, win_last, res_ready, done
    );

    modport slave (
        output start, base, stride, ksize, mem_rdata, win_ready,
               res_valid, res_data, res_addr,
        input  busy, mem_index, mem_write, mem_write_data, mem_write_all,
               win_valid, win_data, win_last, res_ready, done
    );
endinterface

// File: rtl/mem_window_reader.sv
// Streams a KxK memory window, then writes back one result word.
// Optional feature: define MEM_DUMP_EN to pulse mem_write_all in the DONE cycle.
module mem_window_reader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_window_reader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_RES,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    logic col_end;
    logic win_end;

    assign col_end = (col_q == k_q - 2'd1);
    assign win_end = col_end && (row_q == k_q - 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            row_q      <= row_d;
            col_q      <= col_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        row_d      = row_q;
        col_d      = col_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d        = (bus.ksize == 2'd0) ? 2'd1 : bus.ksize;
                    stride_d   = bus.stride;
                    row_base_d = bus.base;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (bus.win_ready) begin
                    // Row address is accumulated so no multiplier is needed.
                    if (col_end) begin
                        col_d      = '0;
                        row_d      = row_q + 2'd1;
                        row_base_d = row_base_q + stride_q;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                    if (win_end) state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (bus.res_valid) begin
                    res_addr_d = bus.res_addr;
                    res_data_d = bus.res_data;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_index = '0;
        case (state_q)
            S_READ:  bus.mem_index = row_base_q + ADDR_W'(col_q);
            S_WRITE: bus.mem_index = res_addr_q;
            default: bus.mem_index = '0;
        endcase
    end

    always_comb begin
        bus.busy           = (state_q != S_IDLE);
        bus.win_valid      = 1'b0;
        bus.win_last       = 1'b0;
        bus.res_ready      = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_write_data = '0;
        bus.done           = 1'b0;
        case (state_q)
            S_READ: begin
                bus.win_valid = 1'b1;
                bus.win_last  = win_end;
            end
            S_WAIT_RES: bus.res_ready = 1'b1;
            S_WRITE: begin
                bus.mem_write      = 1'b1;
                bus.mem_write_data = res_data_q;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Read data passes straight through in READ so the window has no added latency.
    assign bus.win_data = (state_q == S_READ) ? bus.mem_rdata : '0;

`ifdef MEM_DUMP_EN
    assign bus.mem_write_all = (state_q == S_DONE);
`else
    assign bus.mem_write_all = 1'b0;
`endif

endmodule
